// File: rtl/ahb3lite_sram_wait.sv
// AHB3-Lite SRAM slave with a fixed number of wait states per OKAY transfer
// and a two-cycle ERROR response for oversize, misaligned or out-of-range accesses.
module ahb3lite_sram_wait #(
  parameter int DATA_WIDTH  = 32,
  parameter int DEPTH       = 1024,
  parameter int WAIT_STATES = 0,
  parameter int ERR_ON_OOR  = 1
) (
  input  logic                  HCLK,
  input  logic                  HRESETn,
  input  logic                  HSEL,
  input  logic [31:0]           HADDR,
  input  logic [DATA_WIDTH-1:0] HWDATA,
  output logic [DATA_WIDTH-1:0] HRDATA,
  input  logic                  HWRITE,
  input  logic [2:0]            HSIZE,
  input  logic [2:0]            HBURST,
  input  logic [3:0]            HPROT,
  input  logic [1:0]            HTRANS,
  input  logic                  HREADY,
  output logic                  HREADYOUT,
  output logic                  HRESP
);
  localparam int          BYTES     = DATA_WIDTH / 8;
  localparam int          LANE_W    = $clog2(BYTES);
  localparam int          IDX_W     = $clog2(DEPTH);
  localparam logic [2:0]  MAX_SIZE  = 3'(LANE_W);
  localparam logic [63:0] MEM_BYTES = 64'(DEPTH) * 64'(BYTES);
  localparam logic [3:0]  WS        = 4'(WAIT_STATES);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ERR1, S_ERR2} state_t;

  state_t                  state_q;
  logic [3:0]              cnt_q;
  logic                    hreadyout_q, hresp_q;
  logic [DATA_WIDTH-1:0]   hrdata_q, hrdata_d;
  logic                    dp_vld_q, dp_write_q;
  logic [IDX_W-1:0]        dp_idx_q;
  logic [BYTES-1:0]        dp_be_q;

  logic [DATA_WIDTH-1:0]   mem [DEPTH];

  logic                    accept, illegal, size_bad, misalign, oor;
  logic [31:0]             amask;
  logic [IDX_W-1:0]        a_idx, rd_idx;
  logic [LANE_W-1:0]       a_lane;
  logic [BYTES-1:0]        a_be;
  logic                    wr_commit, rd_load;
  logic [DATA_WIDTH-1:0]   old_word, wr_word;
  logic                    unused_ok;

  assign unused_ok = ^{HBURST, HPROT, HTRANS[0]};

  // Only IDLE/ERR2 are cycles in which this slave drives HREADYOUT high.
  assign accept   = HSEL && HREADY && HTRANS[1] && (state_q == S_IDLE || state_q == S_ERR2);
  assign size_bad = HSIZE > MAX_SIZE;
  assign amask    = (32'd1 << HSIZE) - 32'd1;
  assign misalign = |(HADDR & amask);
  assign oor      = (ERR_ON_OOR != 0) && ({32'd0, HADDR} >= MEM_BYTES);
  assign illegal  = size_bad || misalign || oor;

  assign a_idx  = HADDR[IDX_W+LANE_W-1:LANE_W];
  assign a_lane = HADDR[LANE_W-1:0];

  // Aligned access: byte b is selected when it shares the lane bits above HSIZE.
  always_comb begin
    a_be = '0;
    for (int b = 0; b < BYTES; b++)
      a_be[b] = ((LANE_W'(b) ^ a_lane) >> HSIZE) == '0;
  end

  // An OKAY data phase completes in the IDLE state with its pending bit set.
  assign wr_commit = dp_vld_q && dp_write_q && (state_q == S_IDLE);
  assign old_word  = mem[dp_idx_q];

  for (genvar b = 0; b < BYTES; b++) begin : g_lane
    assign wr_word[8*b +: 8] = dp_be_q[b] ? HWDATA[8*b +: 8] : old_word[8*b +: 8];
  end

  // Read data is registered on the edge entering the completing cycle; a write
  // completing on that same edge is forwarded so back-to-back reads see it.
  assign rd_idx   = (state_q == S_WAIT) ? dp_idx_q : a_idx;
  assign hrdata_d = (wr_commit && dp_idx_q == rd_idx) ? wr_word : mem[rd_idx];
  assign rd_load  = (accept && !illegal && !HWRITE && WS == 4'd0) ||
                    (state_q == S_WAIT && cnt_q == 4'd1 && !dp_write_q);

  always_ff @(posedge HCLK) begin
    if (wr_commit) mem[dp_idx_q] <= wr_word;
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q     <= S_IDLE;
      cnt_q       <= 4'd0;
      hreadyout_q <= 1'b1;
      hresp_q     <= 1'b0;
      hrdata_q    <= '0;
      dp_vld_q    <= 1'b0;
      dp_write_q  <= 1'b0;
      dp_idx_q    <= '0;
      dp_be_q     <= '0;
    end else begin
      if (rd_load) hrdata_q <= hrdata_d;
      case (state_q)
        S_WAIT: begin
          if (cnt_q == 4'd1) begin
            state_q     <= S_IDLE;
            hreadyout_q <= 1'b1;
          end
          cnt_q <= cnt_q - 4'd1;
        end
        S_ERR1: begin
          state_q     <= S_ERR2;
          hreadyout_q <= 1'b1;
          hresp_q     <= 1'b1;
        end
        default: begin
          dp_vld_q    <= 1'b0;
          state_q     <= S_IDLE;
          hreadyout_q <= 1'b1;
          hresp_q     <= 1'b0;
          if (accept) begin
            if (illegal) begin
              state_q     <= S_ERR1;
              hreadyout_q <= 1'b0;
              hresp_q     <= 1'b1;
            end else begin
              dp_vld_q   <= 1'b1;
              dp_write_q <= HWRITE;
              dp_idx_q   <= a_idx;
              dp_be_q    <= a_be;
              if (WS != 4'd0) begin
                state_q     <= S_WAIT;
                cnt_q       <= WS;
                hreadyout_q <= 1'b0;
              end
            end
          end
        end
      endcase
    end
  end

  assign HREADYOUT = hreadyout_q;
  assign HRESP     = hresp_q;
  assign HRDATA    = hrdata_q;
endmodule

// File: doc/ahb3lite_sram_wait.md
AHB3LITE_SRAM_WAIT -- requirements
Module: ahb3lite_sram_wait

Interface
REQ-001 Parameter DATA_WIDTH, default 32, meaning bus data width in bits; legal values are 32 and 64.
REQ-002 Parameter DEPTH, default 1024, meaning number of DATA_WIDTH words; must be a power of two, at least 2.
REQ-003 Parameter WAIT_STATES, default 0, meaning HREADYOUT-low cycles inserted per OKAY transfer; legal range is 0..15.
REQ-004 Parameter ERR_ON_OOR, default 1, meaning 1 returns ERROR on an out-of-range address and 0 wraps the address modulo the memory size.
REQ-005 Clock and reset: one clock; reset is asynchronous and active-low. HCLK input, 1 bit, clock. HRESETn input, 1 bit, reset.
REQ-006 HSEL  input  1  slave select.
REQ-007 HADDR  input  32  byte address.
REQ-008 HWDATA  input  DATA_WIDTH  write data, valid in the data phase.
REQ-009 HRDATA  output  DATA_WIDTH  read data.
REQ-010 HWRITE  input  1  1 means write.
REQ-011 HSIZE  input  3  transfer size.
REQ-012 HBURST  input  3  burst type; accepted and ignored.
REQ-013 HPROT  input  4  protection; accepted and ignored.
REQ-014 HTRANS  input  2  transfer type: IDLE=0, BUSY=1, NONSEQ=2, SEQ=3.
REQ-015 HREADY  input  1  bus ready.
REQ-016 HREADYOUT  output  1  slave ready.
REQ-017 HRESP  output  1  0 means OKAY, 1 means ERROR.

Function
REQ-018 An address phase SHALL be accepted on a rising HCLK edge only when HSEL=1, HREADY=1 and HTRANS is NONSEQ or SEQ; the block registers HADDR, HWRITE and HSIZE at that edge.
REQ-019 When HSEL=0, or HTRANS is IDLE or BUSY, with HREADY=1, the next cycle SHALL give HREADYOUT=1 and HRESP=0 with no memory access.
REQ-020 FSM states: IDLE, WAIT, ERR1, ERR2.
REQ-021 From IDLE or ERR2, a legal accepted transfer SHALL go to WAIT when WAIT_STATES>0 and otherwise stay in IDLE, completing in 1 cycle.
REQ-022 In WAIT, a down-counter loaded with WAIT_STATES SHALL hold HREADYOUT=0, HRESP=0 for exactly WAIT_STATES cycles; HREADYOUT=1 SHALL follow in the next cycle.
REQ-023 Latency: an OKAY transfer SHALL complete WAIT_STATES+1 cycles after its address phase.
REQ-024 A transfer is illegal in any of these cases, and an accepted illegal transfer SHALL go to ERR1:
- HSIZE encodes more than DATA_WIDTH bits;
- HADDR is not aligned to HSIZE;
- ERR_ON_OOR=1 and HADDR >= DEPTH*DATA_WIDTH/8.
REQ-025 The ERROR response is two cycles:
- ERR1: HREADYOUT=0, HRESP=1, always followed by ERR2;
- ERR2: HREADYOUT=1, HRESP=1.
An illegal transfer SHALL never modify memory, and WAIT_STATES SHALL not apply to it.
REQ-026 A new address phase presented in the ERR2 cycle SHALL be accepted normally.
REQ-027 Write: on the completing edge of the data phase, only the byte lanes selected by HSIZE and HADDR[log2(DATA_WIDTH/8)-1:0] SHALL be updated from the matching HWDATA lanes; little-endian lane mapping.
REQ-028 Read: HRDATA SHALL present the full addressed word while HREADYOUT=1 ends a read data phase; unselected lanes carry memory contents.
REQ-029 HRDATA SHALL hold its last value in all other cycles.
REQ-030 Memory word index = HADDR[log2(DEPTH)+log2(DATA_WIDTH/8)-1 : log2(DATA_WIDTH/8)].
REQ-031 When ERR_ON_OOR=0, higher address bits SHALL be ignored (wrap-around).
REQ-032 A read immediately following a write to the same word SHALL return the newly written data, at any WAIT_STATES.
REQ-033 HWDATA SHALL be sampled only on the completing edge; its value during wait cycles is ignored.

Reset
REQ-034 While HRESETn=0, the block SHALL force:
- FSM state IDLE and wait counter 0;
- HREADYOUT=1, HRESP=0, HRDATA=0.
REQ-035 Reset asserted mid-transfer SHALL abort it with no memory write; memory contents are not reset.
REQ-036 The first address phase SHALL be accepted on the first rising HCLK edge after HRESETn deasserts.

Verification
REQ-037 WAIT_STATES=0, DATA_WIDTH=32: write word 0xDEADBEEF to 0x10, then read 0x10 back-to-back -> HRDATA=0xDEADBEEF on the next cycle, HREADYOUT never low, HRESP=0.
REQ-038 WAIT_STATES=3: single write then read of 0x20 -> HREADYOUT low for exactly 3 cycles per transfer, read data correct on completion.
REQ-039 Byte write of 0xAA to 0x13 over word 0x11223344 at 0x10 -> read 0x10 returns 0xAA223344.
REQ-040 ERR_ON_OOR=1, DEPTH=1024: read 0x1000 -> ERR1 (HREADYOUT=0, HRESP=1) then ERR2 (HREADYOUT=1, HRESP=1); memory unchanged. Halfword at 0x01 -> same two-cycle ERROR.
REQ-041 HRESETn pulsed low during a WAIT cycle of a write to 0x30 -> HREADYOUT=1, HRESP=0, HRDATA=0 immediately; a later read of 0x30 returns the prior contents.
REQ-042 DATA_WIDTH=64: HSIZE=3 write 0x0123456789ABCDEF to 0x08 -> read returns it unchanged; HSIZE=4 -> ERROR.
